// File: rtl/des_subkey_gen_dec.sv
// DES key schedule, decryption order: emits K16 first down to K1.
// C/D are rotated right between beats, undoing the encryption left shifts.
// One registered 48-bit subkey per valid/ready handshake; done pulses after K1.
module des_subkey_gen_dec #(
  parameter int unsigned NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key_in,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  typedef enum logic {IDLE, RUN} state_t;

  // Counter width follows NUM_ROUNDS; it must match the 4-bit round_idx port.
  localparam int unsigned CNT_W = $clog2(NUM_ROUNDS);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_ROUNDS - 1);

  // Permuted choice 1: FIPS bit numbers (1 = MSB of key_in), C half then D half.
  localparam int unsigned PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // Permuted choice 2: FIPS bit numbers into C||D (1 = MSB of C).
  localparam int unsigned PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int unsigned i = 0; i < 56; i++) begin
      r[55-i] = key[64-PC1_TBL[i]];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int unsigned i = 0; i < 48; i++) begin
      r[47-i] = cd[56-PC2_TBL[i]];
    end
    return r;
  endfunction

  // Right rotation toward higher FIPS bit numbers (bit 1 is the MSB).
  function automatic logic [27:0] rotr(input logic [27:0] v, input logic two);
    return two ? {v[1:0], v[27:2]} : {v[0], v[27:1]};
  endfunction

  state_t            state, state_nxt;
  logic [27:0]       c_q, d_q;
  logic [27:0]       c_rot, d_rot;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  nidx;
  logic [47:0]       subkey_q;
  logic              done_q;
  logic              hs;
  logic              last_beat;
  logic              rot_two;
  logic [55:0]       key_cd;

  assign hs        = subkey_valid & subkey_ready;
  assign last_beat = hs & (cnt_q == LAST_IDX);
  assign key_cd    = pc1(key_in);

  // Rotation for the index being entered; the wrap back to 0 rotates by 1
  // so the full pass totals 28 and C/D return to C0/D0.
  always_comb begin
    nidx    = cnt_q + CNT_W'(1);
    rot_two = !((nidx == CNT_W'(1)) || (nidx == CNT_W'(8)) ||
                (nidx == CNT_W'(15)) || (nidx == '0));
    c_rot   = rotr(c_q, rot_two);
    d_rot   = rotr(d_q, rot_two);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: start only sampled in IDLE, RUN ends on the K1 handshake.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start)     state_nxt = RUN;
      RUN:  if (last_beat) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    busy         = 1'b0;
    subkey_valid = 1'b0;
    if (state == RUN) begin
      busy         = 1'b1;
      subkey_valid = 1'b1;
    end
  end

  // Key registers, round counter, registered subkey and done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      c_q      <= '0;
      d_q      <= '0;
      cnt_q    <= '0;
      subkey_q <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          c_q      <= key_cd[55:28];
          d_q      <= key_cd[27:0];
          cnt_q    <= '0;
          subkey_q <= pc2(key_cd);
        end
      end else if (hs) begin
        c_q <= c_rot;
        d_q <= d_rot;
        if (last_beat) begin
          // Subkey intentionally holds K1 after the final beat.
          cnt_q  <= '0;
          done_q <= 1'b1;
        end else begin
          cnt_q    <= nidx;
          subkey_q <= pc2({c_rot, d_rot});
        end
      end
    end
  end

  assign subkey    = subkey_q;
  assign round_idx = cnt_q;
  assign done      = done_q;

endmodule

// File: tb/tb_des_subkey_gen_dec.sv
// Scoreboard bench for des_subkey_gen_dec: the stimulus side pushes the
// expected decryption-order subkeys from a forward FIPS key-schedule model,
// and a negedge monitor pops and compares on every handshake.
module tb_des_subkey_gen_dec;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [63:0] key_in;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  des_subkey_gen_dec #(.NUM_ROUNDS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .key_in       (key_in),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
  );

  int compared   = 0;
  int mismatched = 0;

  localparam logic [63:0] STD_KEY = 64'h133457799BBCDFF1;

  int PC1 [56] = '{57,49,41,33,25,17,9,1,58,50,42,34,26,18,
                   10,2,59,51,43,35,27,19,11,3,60,52,44,36,
                   63,55,47,39,31,23,15,7,62,54,46,38,30,22,
                   14,6,61,53,45,37,29,21,13,5,28,20,12,4};
  int PC2 [48] = '{14,17,11,24,1,5,3,28,15,6,21,10,
                   23,19,12,4,26,8,16,7,27,20,13,2,
                   41,52,31,37,47,55,30,40,51,45,33,48,
                   44,49,39,56,34,53,46,42,50,36,29,32};
  int SHIFTS [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

  typedef struct packed {
    logic [47:0] key;
    logic [3:0]  idx;
    logic        is_std;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] known(input logic [3:0] idx);
    case (idx)
      4'd0:    return 48'hCB3D8B0E17F5;
      4'd14:   return 48'h79AED9DBC9E5;
      default: return 48'h1B02EFFC7072;
    endcase
  endfunction

  // Forward FIPS schedule (left shifts, K1..K16), queued in reverse order.
  task automatic push_expected(input logic [63:0] key, input bit is_std);
    bit kb [1:64];
    bit c [0:27];
    bit d [0:27];
    bit t;
    logic [47:0] ks [16];
    exp_t e;
    for (int n = 1; n <= 64; n++) kb[n] = key[64-n];
    for (int i = 0; i < 28; i++) begin
      c[i] = kb[PC1[i]];
      d[i] = kb[PC1[28+i]];
    end
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SHIFTS[r]; s++) begin
        t = c[0];
        for (int i = 0; i < 27; i++) c[i] = c[i+1];
        c[27] = t;
        t = d[0];
        for (int i = 0; i < 27; i++) d[i] = d[i+1];
        d[27] = t;
      end
      for (int i = 0; i < 48; i++) begin
        ks[r][47-i] = (PC2[i] <= 28) ? c[PC2[i]-1] : d[PC2[i]-29];
      end
    end
    for (int j = 0; j < 16; j++) begin
      e.key    = ks[15-j];
      e.idx    = 4'(j);
      e.is_std = is_std;
      sb.push_back(e);
    end
  endtask

  // Monitor: handshake scoreboard, done timing, stall stability, idle checks.
  bit          done_exp = 0;
  bit          stalled  = 0;
  logic [47:0] prev_key;
  logic [3:0]  prev_idx;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      done_exp = 0;
      stalled  = 0;
    end else begin
      chk("done", {63'd0, done}, {63'd0, done_exp});
      done_exp = 0;
      chk("busy_eq_valid", {63'd0, busy}, {63'd0, subkey_valid});
      if (!subkey_valid) chk("idle_idx", {60'd0, round_idx}, 64'd0);
      if (stalled) begin
        chk("stall_valid", {63'd0, subkey_valid}, 64'd1);
        chk("stall_subkey", {16'd0, subkey}, {16'd0, prev_key});
        chk("stall_idx", {60'd0, round_idx}, {60'd0, prev_idx});
      end
      if (subkey_valid && subkey_ready) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_beat: got idx %0d subkey %h expected no beat", round_idx, subkey);
        end else begin
          e = sb.pop_front();
          chk("subkey", {16'd0, subkey}, {16'd0, e.key});
          chk("round_idx", {60'd0, round_idx}, {60'd0, e.idx});
          if (e.is_std && (e.idx == 4'd0 || e.idx == 4'd14 || e.idx == 4'd15))
            chk($sformatf("known_k%0d", 16 - e.idx), {16'd0, subkey}, {16'd0, known(e.idx)});
          if (e.idx == 4'd15) done_exp = 1;
        end
      end
      stalled  = subkey_valid && !subkey_ready;
      prev_key = subkey;
      prev_idx = round_idx;
    end
  end

  function automatic logic pick_ready(input bit rnd);
    return rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  endfunction

  task automatic issue(input logic [63:0] key, input bit is_std, input bit rnd);
    start        = 1'b1;
    key_in       = key;
    subkey_ready = pick_ready(rnd);
    push_expected(key, is_std);
    @(posedge clk); #1;
    start        = 1'b0;
    key_in       = {$urandom, $urandom};
    subkey_ready = pick_ready(rnd);
    chk("start_latency", {63'd0, subkey_valid}, 64'd1);
  endtask

  task automatic idle_checks(input string tag);
    chk({tag, "_valid"}, {63'd0, subkey_valid}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_idx"}, {60'd0, round_idx}, 64'd0);
    chk({tag, "_subkey"}, {16'd0, subkey}, 64'd0);
  endtask

  // Runs the current schedule until the scoreboard empties (the done cycle).
  // chain_zero starts a weak-key schedule in that done cycle.
  task automatic drain(input bit rnd, input bit busy_start, input bit rst_at7, input bit chain_zero);
    bit injected = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (sb.size() == 0) begin
        if (chain_zero) issue(64'h0101010101010101, 1'b0, rnd);
        return;
      end
      subkey_ready = pick_ready(rnd);
      if (busy_start && !injected && subkey_valid && round_idx == 4'd5) begin
        start    = 1'b1;
        key_in   = 64'd0;
        injected = 1;
      end
      if (rst_at7 && subkey_valid && round_idx == 4'd7) begin
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        idle_checks("abort");
        return;
      end
    end
    compared++;
    mismatched++;
    $display("FAIL drain_timeout: got %0d beats outstanding expected 0", sb.size());
    sb.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic settle();
    repeat (2) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    subkey_ready = 1'b0;
    key_in       = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    idle_checks("reset");

    // Standard key, ready held high.
    @(posedge clk); #1;
    issue(STD_KEY, 1'b1, 1'b0);
    drain(1'b0, 1'b0, 1'b0, 1'b0);
    settle();

    // Parity-only variant must give the same sequence as the standard key.
    issue(64'h123457799ABCDEF0, 1'b1, 1'b0);
    drain(1'b0, 1'b0, 1'b0, 1'b0);
    settle();

    // Weak keys.
    issue(64'h0101010101010101, 1'b0, 1'b0);
    drain(1'b0, 1'b0, 1'b0, 1'b0);
    settle();
    issue(64'hFEFEFEFEFEFEFEFE, 1'b0, 1'b0);
    drain(1'b0, 1'b0, 1'b0, 1'b0);
    settle();

    // Backpressure with random ready.
    issue(STD_KEY, 1'b1, 1'b1);
    drain(1'b1, 1'b0, 1'b0, 1'b0);
    settle();

    // Ignored start at round 5, then a new start in the done cycle.
    issue(STD_KEY, 1'b1, 1'b1);
    drain(1'b1, 1'b1, 1'b0, 1'b1);
    drain(1'b0, 1'b0, 1'b0, 1'b0);
    settle();

    // Reset at round 7, then a clean restart.
    issue(STD_KEY, 1'b1, 1'b0);
    drain(1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    issue(STD_KEY, 1'b1, 1'b0);
    drain(1'b0, 1'b0, 1'b0, 1'b0);
    settle();

    // Random keys, random backpressure.
    for (int k = 0; k < 6; k++) begin
      issue({$urandom, $urandom}, 1'b0, 1'b1);
      drain(1'b1, 1'b0, 1'b0, 1'b0);
      settle();
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
